bayer_mosaic: RTL and testbench
===============================

BAYER_MOSAIC -- requirements
Module: bayer_mosaic

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 10, width of each input color channel.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, width of meta_datai and datao.
REQ-003 SHALL have parameter NUM_COLS_WIDTH, default 11, width of the internal column counters.
REQ-004 SHALL use one clock and a synchronous, active-high reset: ports clk and reset.
REQ-005 SHALL have ports in this order:
- clk, input, 1, clock.
- reset, input, 1, synchronous active-high reset.
- enable, input, 1, block enable.
- dvi, input, 1, input token valid.
- dtypei, input, `DTYPE_WIDTH, input token type.
- r, input, PIXEL_WIDTH, red channel.
- g, input, PIXEL_WIDTH, green channel.
- b, input, PIXEL_WIDTH, blue channel.
- meta_datai, input, DATA_WIDTH, data carried by non-pixel tokens.
- phase, input, 2, Bayer phase {row, col}.
- dvo, output, 1, output valid.
- dtypeo, output, `DTYPE_WIDTH, output token type.
- datao, output, DATA_WIDTH, mosaic pixel or metadata.
- proto_err, output, 1, sticky protocol error.

Function
REQ-006 Each accepted token (dvi=1, enable=1) SHALL appear on the outputs exactly 1 cycle later with dvo=1 and dtypeo=dtypei; dvo SHALL be 0 in every other cycle.
REQ-007 Phase tracking:
- DTYPE_FRAME_START latches row_phase<=phase[1].
- DTYPE_ROW_START latches col_phase<=phase[0].
- DTYPE_ROW_END toggles row_phase.
- Each pixel token (dtypei & DTYPE_PIXEL_MASK nonzero) toggles col_phase.
REQ-008 Pixel channel selection SHALL use {row_phase,col_phase} before the toggle: 0 selects r, 1 selects g, 2 selects g, 3 selects b. datao SHALL be the selected channel zero-extended to DATA_WIDTH.
REQ-009 For non-pixel tokens, datao SHALL equal meta_datai unchanged.
REQ-010 FSM states:
- IDLE goes to FRAME on FRAME_START.
- FRAME goes to ROW on ROW_START.
- ROW goes to FRAME on ROW_END.
- FRAME goes to IDLE on FRAME_END.
REQ-011 FSM resync: FRAME_START received in any state SHALL go to FRAME and reload row_phase. Every other out-of-order token SHALL leave the state unchanged and still be forwarded per REQ-006..009.
REQ-012 A pixel token received outside ROW SHALL still be forwarded using the current phase.
REQ-013 With enable=0: dvo=0, the FSM is forced to IDLE, and the phase registers hold their values; proto_err holds.

Reset
REQ-014 While reset=1, the following SHALL all be 0 on the next clk edge: dvo, dtypeo, datao, proto_err, row_phase, col_phase, and all counters; the FSM SHALL be IDLE.
REQ-015 Reset asserted mid-row SHALL discard the in-flight token; the output stream resumes only at the next FRAME_START.
REQ-016 When reset and enable=0 are both asserted, reset SHALL take precedence.

Configuration
REQ-017 Macro BAYER_MOSAIC_CHECK_EN, when defined, SHALL enable the protocol checker. proto_err SHALL be set, and SHALL stay set until reset or the next FRAME_START taken in IDLE, on any of:
- an out-of-order token per REQ-011;
- a pixel outside ROW;
- a row whose pixel count differs from the first row of the frame (counted by NUM_COLS_WIDTH counters; counter wrap counts as a mismatch).
REQ-018 Without BAYER_MOSAIC_CHECK_EN, proto_err SHALL be tied to 0 and no checker counters SHALL be synthesized; the data path SHALL be identical to REQ-006..013.

Structure
REQ-019 Token type codes and the DTYPE_* constants SHALL come from the shared dtypes.v include; no local redefinition.
REQ-020 The FSM state encoding SHALL be local to the module.
REQ-021 The checker SHALL be a sub-module bayer_mosaic_check, instantiated only under BAYER_MOSAIC_CHECK_EN.

Verification
REQ-022 Phase 0, 2x2 frame, r=100, g=200, b=300 on every pixel -> datao pixels 100, 200 (row 0) and 200, 300 (row 1), each one cycle after input.
REQ-023 Phase 3, same frame -> datao 300, 200 (row 0) and 200, 100 (row 1).
REQ-024 ROW_START with meta_datai=0x1234 -> dtypeo=ROW_START and datao=0x1234 one cycle later.
REQ-025 Checker on: rows of 4 then 3 pixels -> proto_err=1 after the second ROW_END; next FRAME_START from IDLE clears it. Checker off: proto_err stays 0.
REQ-026 reset pulsed after pixel 2 of row 0 -> next-cycle dvo=0, datao=0; no output until FRAME_START; the following frame matches REQ-022.
REQ-027 enable=0 for 3 cycles mid-row with dvi=1 -> dvo=0 during those cycles; the next ROW_START is flagged when the checker is on.

Source files
------------

// File: rtl/bayer_mosaic_pkg.sv
// Shared types and helpers for the Bayer mosaic block.
`include "dtypes.v"

package bayer_mosaic_pkg;

    typedef enum logic [1:0] {
        SEL_R  = 2'd0,
        SEL_GR = 2'd1,
        SEL_GB = 2'd2,
        SEL_B  = 2'd3
    } chan_sel_e;

    function automatic logic is_pixel(input logic [`DTYPE_WIDTH-1:0] dtype);
        return (dtype & `DTYPE_PIXEL_MASK) != {`DTYPE_WIDTH{1'b0}};
    endfunction

endpackage

// File: rtl/bayer_mosaic_check.sv
// Protocol checker: sticky flag for out-of-order tokens, stray pixels and uneven rows.
`include "dtypes.v"

module bayer_mosaic_check
    import bayer_mosaic_pkg::*;
#(
    parameter int NUM_COLS_WIDTH = 11
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    accept,
    input  logic [`DTYPE_WIDTH-1:0] dtype,
    input  logic                    in_idle,
    input  logic                    in_row,
    input  logic                    token_err,
    output logic                    proto_err
);

    logic [NUM_COLS_WIDTH-1:0] count_r;
    logic [NUM_COLS_WIDTH-1:0] first_count_r;
    logic                      wrap_r;
    logic                      have_first_r;
    logic                      err_r;
    logic                      row_start_s;
    logic                      frame_start_s;
    logic                      clear_s;
    logic                      pixel_in_row_s;
    logic                      row_done_s;
    logic                      row_mismatch_s;

    // Decode the accepted token into checker events.
    always_comb begin
        row_start_s    = accept && (dtype == `DTYPE_ROW_START);
        frame_start_s  = accept && (dtype == `DTYPE_FRAME_START);
        clear_s        = frame_start_s && in_idle;
        pixel_in_row_s = accept && is_pixel(dtype) && in_row;
        row_done_s     = accept && (dtype == `DTYPE_ROW_END) && in_row;
        row_mismatch_s = row_done_s &&
                         (wrap_r || (have_first_r && (count_r != first_count_r)));
    end

    // Pixel counter for the current row; a wrap is remembered as a mismatch.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
            wrap_r  <= 1'b0;
        end else if (row_start_s) begin
            count_r <= '0;
            wrap_r  <= 1'b0;
        end else if (pixel_in_row_s) begin
            count_r <= count_r + NUM_COLS_WIDTH'(1);
            if (&count_r) begin
                wrap_r <= 1'b1;
            end
        end
    end

    // Reference length taken from the first completed row of each frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            first_count_r <= '0;
            have_first_r  <= 1'b0;
        end else if (frame_start_s) begin
            have_first_r  <= 1'b0;
        end else if (row_done_s && !have_first_r) begin
            first_count_r <= count_r;
            have_first_r  <= 1'b1;
        end
    end

    // Sticky error, released only by a clean frame start from idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_r <= 1'b0;
        end else if (clear_s) begin
            err_r <= 1'b0;
        end else if (token_err || row_mismatch_s) begin
            err_r <= 1'b1;
        end
    end

    assign proto_err = err_r;

endmodule

// File: rtl/dtypes.v
// Shared token type codes for the video streaming blocks.
`ifndef DTYPES_V
`define DTYPES_V

`define DTYPE_WIDTH        4
`define DTYPE_FRAME_START  4'h1
`define DTYPE_FRAME_END    4'h2
`define DTYPE_ROW_START    4'h3
`define DTYPE_ROW_END      4'h4
`define DTYPE_PIXEL        4'h8
`define DTYPE_PIXEL_MASK   4'h8

`endif

// File: rtl/bayer_mosaic.sv
// RGB to Bayer mosaic token stream converter with one cycle latency.
// Optional protocol checker enabled by defining BAYER_MOSAIC_CHECK_EN.
`include "dtypes.v"

module bayer_mosaic
    import bayer_mosaic_pkg::*;
#(
    parameter int PIXEL_WIDTH    = 10,
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_COLS_WIDTH = 11
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    dvi,
    input  logic [`DTYPE_WIDTH-1:0] dtypei,
    input  logic [PIXEL_WIDTH-1:0]  r,
    input  logic [PIXEL_WIDTH-1:0]  g,
    input  logic [PIXEL_WIDTH-1:0]  b,
    input  logic [DATA_WIDTH-1:0]   meta_datai,
    input  logic [1:0]              phase,
    output logic                    dvo,
    output logic [`DTYPE_WIDTH-1:0] dtypeo,
    output logic [DATA_WIDTH-1:0]   datao,
    output logic                    proto_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_ROW   = 2'd2
    } state_e;

    state_e                    state_r;
    state_e                    state_next_s;
    logic                      accept_s;
    logic                      pixel_s;
    logic                      in_idle_s;
    logic                      in_row_s;
    logic                      token_err_s;
    logic                      row_phase_r;
    logic                      col_phase_r;
    logic [PIXEL_WIDTH-1:0]    chan_s;
    logic                      dvo_r;
    logic [`DTYPE_WIDTH-1:0]   dtypeo_r;
    logic [DATA_WIDTH-1:0]     datao_r;

    assign accept_s = enable && dvi;
    assign pixel_s  = is_pixel(dtypei);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state; FRAME_START resyncs from anywhere, other stray tokens are ignored.
    always_comb begin
        state_next_s = state_r;
        if (!enable) begin
            state_next_s = ST_IDLE;
        end else if (!dvi) begin
            state_next_s = state_r;
        end else if (dtypei == `DTYPE_FRAME_START) begin
            state_next_s = ST_FRAME;
        end else begin
            case (state_r)
                ST_FRAME: begin
                    if (dtypei == `DTYPE_ROW_START) begin
                        state_next_s = ST_ROW;
                    end else if (dtypei == `DTYPE_FRAME_END) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = state_r;
                    end
                end
                ST_ROW: begin
                    if (dtypei == `DTYPE_ROW_END) begin
                        state_next_s = ST_FRAME;
                    end else begin
                        state_next_s = state_r;
                    end
                end
                default: state_next_s = state_r;
            endcase
        end
    end

    // State-derived flags: legality of the accepted token.
    always_comb begin
        in_idle_s   = (state_r == ST_IDLE);
        in_row_s    = (state_r == ST_ROW);
        token_err_s = 1'b0;
        if (accept_s) begin
            case (dtypei)
                `DTYPE_FRAME_START: token_err_s = (state_r != ST_IDLE);
                `DTYPE_ROW_START:   token_err_s = (state_r != ST_FRAME);
                `DTYPE_ROW_END:     token_err_s = (state_r != ST_ROW);
                `DTYPE_FRAME_END:   token_err_s = (state_r != ST_FRAME);
                default:            token_err_s = pixel_s && (state_r != ST_ROW);
            endcase
        end else begin
            token_err_s = 1'b0;
        end
    end

    // Channel pick from the phase seen before this token's toggle.
    always_comb begin
        case (chan_sel_e'({row_phase_r, col_phase_r}))
            SEL_R:   chan_s = r;
            SEL_GR:  chan_s = g;
            SEL_GB:  chan_s = g;
            SEL_B:   chan_s = b;
            default: chan_s = r;
        endcase
    end

    // Output token registers and phase tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            dvo_r       <= 1'b0;
            dtypeo_r    <= '0;
            datao_r     <= '0;
            row_phase_r <= 1'b0;
            col_phase_r <= 1'b0;
        end else if (!enable) begin
            dvo_r <= 1'b0;
        end else begin
            dvo_r <= dvi;
            if (dvi) begin
                dtypeo_r <= dtypei;
                datao_r  <= pixel_s ? DATA_WIDTH'(chan_s) : meta_datai;
                if (dtypei == `DTYPE_FRAME_START) begin
                    row_phase_r <= phase[1];
                end else if (dtypei == `DTYPE_ROW_END) begin
                    row_phase_r <= ~row_phase_r;
                end
                if (dtypei == `DTYPE_ROW_START) begin
                    col_phase_r <= phase[0];
                end else if (pixel_s) begin
                    col_phase_r <= ~col_phase_r;
                end
            end
        end
    end

    assign dvo    = dvo_r;
    assign dtypeo = dtypeo_r;
    assign datao  = datao_r;

`ifdef BAYER_MOSAIC_CHECK_EN
    bayer_mosaic_check #(
        .NUM_COLS_WIDTH (NUM_COLS_WIDTH)
    ) u_check (
        .clk       (clk),
        .reset     (reset),
        .accept    (accept_s),
        .dtype     (dtypei),
        .in_idle   (in_idle_s),
        .in_row    (in_row_s),
        .token_err (token_err_s),
        .proto_err (proto_err)
    );
`else
    localparam int CHECK_COLS_UNUSED = NUM_COLS_WIDTH;
    logic check_unused_s;
    assign check_unused_s = in_idle_s ^ in_row_s ^ token_err_s;
    assign proto_err      = 1'b0;
`endif

endmodule

// File: tb/tb_bayer_mosaic.sv
// Self-checking bench for bayer_mosaic against a token-level reference model.
`include "dtypes.v"

module tb_bayer_mosaic;

    localparam int PW = 10;
    localparam int DW = 16;
    localparam int CW = 11;
`ifdef BAYER_MOSAIC_CHECK_EN
    localparam bit CHECK_ON = 1'b1;
`else
    localparam bit CHECK_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          dvi;
    logic [3:0]    dtypei;
    logic [PW-1:0] r, g, b;
    logic [DW-1:0] meta_datai;
    logic [1:0]    phase;
    logic          dvo;
    logic [3:0]    dtypeo;
    logic [DW-1:0] datao;
    logic          proto_err;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [3:0]    t;
        logic [PW-1:0] rr, gg, bb;
        logic [DW-1:0] meta;
        logic [1:0]    ph;
    } tok_t;

    typedef struct packed {
        logic          dvo;
        logic [3:0]    t;
        logic [DW-1:0] d;
        logic          err;
        logic [3:0]    et;
        logic [DW-1:0] ed;
    } obs_t;

    tok_t q[$];
    obs_t obs[$];
    logic m_row, m_col;

    bayer_mosaic #(.PIXEL_WIDTH(PW), .DATA_WIDTH(DW), .NUM_COLS_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .dvi(dvi), .dtypei(dtypei),
        .r(r), .g(g), .b(b), .meta_datai(meta_datai), .phase(phase),
        .dvo(dvo), .dtypeo(dtypeo), .datao(datao), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    // Reference: Bayer site (row parity, col parity) picks R, G or B; metadata passes through.
    task automatic model_step(input tok_t k, output logic [DW-1:0] res);
        int site;
        site = (m_row ? 2 : 0) + (m_col ? 1 : 0);
        if ((k.t & `DTYPE_PIXEL_MASK) != 4'h0) begin
            if (site == 0)      res = DW'(k.rr);
            else if (site == 3) res = DW'(k.bb);
            else                res = DW'(k.gg);
            m_col = ~m_col;
        end else begin
            res = k.meta;
            if (k.t == `DTYPE_FRAME_START) m_row = k.ph[1];
            if (k.t == `DTYPE_ROW_START)   m_col = k.ph[0];
            if (k.t == `DTYPE_ROW_END)     m_row = ~m_row;
        end
    endtask

    task automatic add(input logic [3:0] t, input logic [1:0] ph, input int vr, input int vg,
                       input int vb, input logic [DW-1:0] meta);
        tok_t k;
        k.t = t;
        if ((t & `DTYPE_PIXEL_MASK) != 4'h0) k.t = t | 4'($urandom_range(0, 7));
        k.rr = PW'(vr); k.gg = PW'(vg); k.bb = PW'(vb);
        k.meta = meta;
        k.ph = ((t & `DTYPE_PIXEL_MASK) != 4'h0) ? 2'($urandom_range(0, 3)) : ph;
        q.push_back(k);
    endtask

    task automatic add_pix(input bit fixed);
        if (fixed) add(`DTYPE_PIXEL, 2'd0, 100, 200, 300, DW'($urandom));
        else add(`DTYPE_PIXEL, 2'd0, $urandom_range(0, 1023), $urandom_range(0, 1023),
                 $urandom_range(0, 1023), DW'($urandom));
    endtask

    task automatic build_frame(input logic [1:0] ph, input int rows, input int cols, input bit fixed);
        add(`DTYPE_FRAME_START, ph, 0, 0, 0, DW'($urandom));
        for (int i = 0; i < rows; i++) begin
            add(`DTYPE_ROW_START, ph, 0, 0, 0, DW'($urandom));
            for (int j = 0; j < cols; j++) add_pix(fixed);
            add(`DTYPE_ROW_END, ph, 0, 0, 0, DW'($urandom));
        end
        add(`DTYPE_FRAME_END, ph, 0, 0, 0, DW'($urandom));
    endtask

    // Drives queued tokens back to back and records what appears one cycle later.
    task automatic play();
        tok_t k;
        obs_t o;
        logic [DW-1:0] e;
        obs.delete();
        while (q.size() > 0) begin
            k = q.pop_front();
            model_step(k, e);
            dvi = 1'b1; dtypei = k.t; r = k.rr; g = k.gg; b = k.bb;
            meta_datai = k.meta; phase = k.ph;
            @(posedge clk); #1;
            o.dvo = dvo; o.t = dtypeo; o.d = datao; o.err = proto_err; o.et = k.t; o.ed = e;
            obs.push_back(o);
        end
        dvi = 1'b0;
    endtask

    task automatic idle(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            dvi = 1'b0; dtypei = 4'($urandom); meta_datai = DW'($urandom);
            @(posedge clk); #1;
            if (dvo !== 1'b0) seen++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; dvi = 1'b1; dtypei = `DTYPE_PIXEL;
        r = 10'd5; g = 10'd6; b = 10'd7; meta_datai = 16'hBEEF; phase = 2'd3;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({dvo, dtypeo, datao, proto_err} !== 22'd0) begin
            bad++;
            $display("FAIL reset_outputs: got dvo=%0b type=%0h data=%0h err=%0b want all 0",
                     dvo, dtypeo, datao, proto_err);
        end
        reset = 1'b0; enable = 1'b1;
        m_row = 1'b0; m_col = 1'b0;
        add(`DTYPE_PIXEL, 2'd0, 11, 22, 33, 16'h0);
        play();
        total++;
        if (obs[0].dvo !== 1'b1 || obs[0].d !== 16'd11 || obs[0].err !== CHECK_ON) begin
            bad++;
            $display("FAIL reset_phase_zero: got dvo=%0b data=%0d err=%0b want dvo=1 data=11 err=%0b",
                     obs[0].dvo, obs[0].d, obs[0].err, CHECK_ON);
        end
    endtask

    task automatic test_fixed_frame(input logic [1:0] ph, input string tag);
        logic [DW-1:0] want [4];
        int k = 0;
        int seen;
        if (ph == 2'd0) want = '{16'd100, 16'd200, 16'd200, 16'd300};
        else            want = '{16'd300, 16'd200, 16'd200, 16'd100};
        add(`DTYPE_FRAME_START, ph, 0, 0, 0, DW'($urandom));
        add(`DTYPE_ROW_START, ph, 0, 0, 0, 16'h1234);
        for (int j = 0; j < 2; j++) add_pix(1'b1);
        add(`DTYPE_ROW_END, ph, 0, 0, 0, DW'($urandom));
        add(`DTYPE_ROW_START, ph, 0, 0, 0, DW'($urandom));
        for (int j = 0; j < 2; j++) add_pix(1'b1);
        add(`DTYPE_ROW_END, ph, 0, 0, 0, DW'($urandom));
        add(`DTYPE_FRAME_END, ph, 0, 0, 0, DW'($urandom));
        play();
        foreach (obs[i]) begin
            total++;
            if (obs[i].dvo !== 1'b1 || obs[i].t !== obs[i].et || obs[i].d !== obs[i].ed) begin
                bad++;
                $display("FAIL %s tok%0d: got dvo=%0b type=%0h data=%0h want dvo=1 type=%0h data=%0h",
                         tag, i, obs[i].dvo, obs[i].t, obs[i].d, obs[i].et, obs[i].ed);
            end
            if ((obs[i].et & `DTYPE_PIXEL_MASK) != 4'h0 && k < 4) begin
                total++;
                if (obs[i].d !== want[k]) begin
                    bad++;
                    $display("FAIL %s pixel%0d: got %0d want %0d", tag, k, obs[i].d, want[k]);
                end
                k++;
            end
        end
        total++;
        if (obs[1].t !== `DTYPE_ROW_START || obs[1].d !== 16'h1234) begin
            bad++;
            $display("FAIL %s row_start_meta: got type=%0h data=%0h want type=3 data=1234",
                     tag, obs[1].t, obs[1].d);
        end
        idle(2, seen);
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL %s idle_dvo: got %0d valid cycles want 0", tag, seen);
        end
    endtask

    task automatic test_random_frames();
        int seen;
        for (int f = 0; f < 6; f++) begin
            build_frame(2'($urandom_range(0, 3)), $urandom_range(1, 4), $urandom_range(1, 6), 1'b0);
            play();
            foreach (obs[i]) begin
                total++;
                if (obs[i].dvo !== 1'b1 || obs[i].t !== obs[i].et || obs[i].d !== obs[i].ed) begin
                    bad++;
                    $display("FAIL random f%0d tok%0d: got dvo=%0b type=%0h data=%0h want dvo=1 type=%0h data=%0h",
                             f, i, obs[i].dvo, obs[i].t, obs[i].d, obs[i].et, obs[i].ed);
                end
            end
            total++;
            if (obs[obs.size()-1].err !== 1'b0) begin
                bad++;
                $display("FAIL random f%0d proto_err: got 1 want 0", f);
            end
            idle($urandom_range(0, 2), seen);
            total++;
            if (seen !== 0) begin
                bad++;
                $display("FAIL random f%0d gap_dvo: got %0d want 0", f, seen);
            end
        end
    endtask

    task automatic test_row_mismatch();
        logic [DW-1:0] m;
        add(`DTYPE_FRAME_START, 2'd1, 0, 0, 0, DW'($urandom));
        add(`DTYPE_ROW_START, 2'd1, 0, 0, 0, DW'($urandom));
        for (int j = 0; j < 4; j++) add_pix(1'b0);
        add(`DTYPE_ROW_END, 2'd1, 0, 0, 0, DW'($urandom));
        add(`DTYPE_ROW_START, 2'd1, 0, 0, 0, DW'($urandom));
        for (int j = 0; j < 3; j++) add_pix(1'b0);
        add(`DTYPE_ROW_END, 2'd1, 0, 0, 0, DW'($urandom));
        add(`DTYPE_FRAME_END, 2'd1, 0, 0, 0, DW'($urandom));
        add(`DTYPE_FRAME_START, 2'd0, 0, 0, 0, DW'($urandom));
        add(`DTYPE_FRAME_END, 2'd0, 0, 0, 0, DW'($urandom));
        play();
        foreach (obs[i]) begin
            total++;
            if (obs[i].dvo !== 1'b1 || obs[i].t !== obs[i].et || obs[i].d !== obs[i].ed) begin
                bad++;
                $display("FAIL mismatch tok%0d: got type=%0h data=%0h want type=%0h data=%0h",
                         i, obs[i].t, obs[i].d, obs[i].et, obs[i].ed);
            end
        end
        m = {15'd0, obs[6].err};
        total++;
        if ({obs[6].err, obs[11].err, obs[12].err, obs[13].err} !== {1'b0, CHECK_ON, CHECK_ON, 1'b0}) begin
            bad++;
            $display("FAIL mismatch proto_err: got row1=%0b row2=%0b fe=%0b fs=%0b want 0 %0b %0b 0",
                     m[0], obs[11].err, obs[12].err, obs[13].err, CHECK_ON, CHECK_ON);
        end
    endtask

    task automatic test_reset_midrow();
        int seen;
        add(`DTYPE_FRAME_START, 2'd0, 0, 0, 0, DW'($urandom));
        add(`DTYPE_ROW_START, 2'd0, 0, 0, 0, DW'($urandom));
        add_pix(1'b0);
        add_pix(1'b0);
        play();
        foreach (obs[i]) begin
            total++;
            if (obs[i].dvo !== 1'b1 || obs[i].t !== obs[i].et || obs[i].d !== obs[i].ed) begin
                bad++;
                $display("FAIL midrow_pre tok%0d: got type=%0h data=%0h want type=%0h data=%0h",
                         i, obs[i].t, obs[i].d, obs[i].et, obs[i].ed);
            end
        end
        reset = 1'b1; dvi = 1'b1; dtypei = `DTYPE_PIXEL; r = 10'd77; g = 10'd88; b = 10'd99;
        @(posedge clk); #1;
        total++;
        if (dvo !== 1'b0 || datao !== 16'd0 || dtypeo !== 4'd0) begin
            bad++;
            $display("FAIL midrow_reset: got dvo=%0b type=%0h data=%0h want 0 0 0", dvo, dtypeo, datao);
        end
        reset = 1'b0;
        m_row = 1'b0; m_col = 1'b0;
        idle(3, seen);
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL midrow_quiet: got %0d valid cycles want 0", seen);
        end
        test_fixed_frame(2'd0, "after_reset");
    endtask

    task automatic test_enable_gap();
        int seen = 0;
        add(`DTYPE_FRAME_START, 2'd2, 0, 0, 0, DW'($urandom));
        add(`DTYPE_ROW_START, 2'd2, 0, 0, 0, DW'($urandom));
        add_pix(1'b0);
        add_pix(1'b0);
        play();
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dvi = 1'b1; dtypei = `DTYPE_PIXEL; r = 10'($urandom); g = 10'($urandom); b = 10'($urandom);
            @(posedge clk); #1;
            if (dvo !== 1'b0) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL enable_gap_dvo: got %0d valid cycles want 0", seen);
        end
        enable = 1'b1;
        add(`DTYPE_ROW_START, 2'd1, 0, 0, 0, DW'($urandom));
        add_pix(1'b0);
        add_pix(1'b0);
        add(`DTYPE_FRAME_START, 2'd0, 0, 0, 0, DW'($urandom));
        add(`DTYPE_ROW_START, 2'd0, 0, 0, 0, DW'($urandom));
        add_pix(1'b0);
        add(`DTYPE_ROW_END, 2'd0, 0, 0, 0, DW'($urandom));
        add(`DTYPE_FRAME_END, 2'd0, 0, 0, 0, DW'($urandom));
        play();
        foreach (obs[i]) begin
            total++;
            if (obs[i].dvo !== 1'b1 || obs[i].t !== obs[i].et || obs[i].d !== obs[i].ed) begin
                bad++;
                $display("FAIL enable_gap tok%0d: got type=%0h data=%0h want type=%0h data=%0h",
                         i, obs[i].t, obs[i].d, obs[i].et, obs[i].ed);
            end
        end
        total++;
        if (obs[0].err !== CHECK_ON || obs[3].err !== 1'b0) begin
            bad++;
            $display("FAIL enable_gap proto_err: got row_start=%0b frame_start=%0b want %0b 0",
                     obs[0].err, obs[3].err, CHECK_ON);
        end
    endtask

    initial begin
        test_reset();
        test_fixed_frame(2'd0, "phase0");
        test_fixed_frame(2'd3, "phase3");
        test_random_frames();
        test_row_mismatch();
        test_reset_midrow();
        test_enable_gap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
